// File: rtl/ball_update_scheduler.sv
// rtl/ball_update_scheduler.sv - once-per-frame motion update sequencer for NUM_BALLS ball slots
// Time-multiplexes one shared motion unit over all slots and serves positions to the color mapper.
module ball_update_scheduler #(
  parameter int         NUM_BALLS = 4,
  parameter int         IDX_W     = 4,
  parameter logic [9:0] X_INIT    = 10'd80,
  parameter logic [9:0] X_SPACING = 10'd120,
  parameter logic [9:0] Y_INIT    = 10'd240,
  parameter int         TIMEOUT   = 64
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             vs,
  input  logic [7:0]       keycode,
  output logic             upd_req,
  output logic [IDX_W-1:0] upd_idx,
  output logic [7:0]       upd_key,
  output logic [9:0]       upd_x,
  output logic [9:0]       upd_y,
  output logic [9:0]       upd_vx,
  output logic [9:0]       upd_vy,
  input  logic             upd_ack,
  input  logic [9:0]       new_x,
  input  logic [9:0]       new_y,
  input  logic [9:0]       new_vx,
  input  logic [9:0]       new_vy,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [9:0]       rd_x,
  output logic [9:0]       rd_y,
  output logic             busy,
  output logic             frame_done,
  output logic             overrun,
  output logic             ack_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, REQ} state_t;
  state_t state, next_state;

  logic             vs_prev;
  logic             fs;
  logic [7:0]       key_reg;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic [9:0]       slot_x [NUM_BALLS];
  logic [9:0]       slot_y [NUM_BALLS];
  logic [9:0]       slot_vx[NUM_BALLS];
  logic [9:0]       slot_vy[NUM_BALLS];
  logic [9:0]       cur_x, cur_y, cur_vx, cur_vy;
  logic             start, expire, advance, last;

  // Compare-based muxes keep the slot arrays exactly NUM_BALLS deep.
  always_comb begin
    cur_x  = 10'd0;
    cur_y  = 10'd0;
    cur_vx = 10'd0;
    cur_vy = 10'd0;
    rd_x   = 10'd0;
    rd_y   = 10'd0;
    for (int i = 0; i < NUM_BALLS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_x  = slot_x[i];
        cur_y  = slot_y[i];
        cur_vx = slot_vx[i];
        cur_vy = slot_vy[i];
      end
      if (rd_idx == IDX_W'(i)) begin
        rd_x = slot_x[i];
        rd_y = slot_y[i];
      end
    end
  end

  assign last = (idx == IDX_W'(NUM_BALLS - 1));

  always_comb begin
    next_state = state;
    start      = 1'b0;
    expire     = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (fs) begin
          next_state = REQ;
          start      = 1'b1;
        end
      end
      REQ: begin
        expire  = !upd_ack && (cnt == CNT_W'(TIMEOUT - 1));
        advance = upd_ack || expire;
        if (advance && last) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign upd_req = (state == REQ);
  assign busy    = upd_req;
  assign upd_idx = upd_req ? idx : '0;
  assign upd_key = (upd_req && idx == '0) ? key_reg : 8'h00;
  assign upd_x   = upd_req ? cur_x  : 10'd0;
  assign upd_y   = upd_req ? cur_y  : 10'd0;
  assign upd_vx  = upd_req ? cur_vx : 10'd0;
  assign upd_vy  = upd_req ? cur_vy : 10'd0;

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      vs_prev     <= 1'b1;
      fs          <= 1'b0;
      key_reg     <= 8'h00;
      idx         <= '0;
      cnt         <= '0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      ack_timeout <= 1'b0;
      for (int i = 0; i < NUM_BALLS; i++) begin
        slot_x[i]  <= X_INIT + 10'(i) * X_SPACING;
        slot_y[i]  <= Y_INIT;
        slot_vx[i] <= 10'd1;
        slot_vy[i] <= 10'd1;
      end
    end else begin
      vs_prev    <= vs;
      fs         <= vs_prev & ~vs;
      frame_done <= advance & last;
      // A frame start that lands on the final slot still counts as an overrun.
      if (fs && state != IDLE) overrun <= 1'b1;
      if (expire) ack_timeout <= 1'b1;
      if (start) begin
        key_reg <= keycode;
        idx     <= '0;
        cnt     <= '0;
      end else if (advance) begin
        cnt <= '0;
        idx <= last ? '0 : idx + 1'b1;
        for (int i = 0; i < NUM_BALLS; i++) begin
          if (upd_ack && idx == IDX_W'(i)) begin
            slot_x[i]  <= new_x;
            slot_y[i]  <= new_y;
            slot_vx[i] <= new_vx;
            slot_vy[i] <= new_vy;
          end
        end
      end else if (state == REQ) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ball_update_scheduler.sv
// tb/tb_ball_update_scheduler.sv - randomized self-checking bench for ball_update_scheduler
// The bench plays the motion unit and keeps its own per-slot model of ball state.
module tb_ball_update_scheduler;
  localparam int N  = 4;
  localparam int IW = 4;
  localparam int TO = 64;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          vs = 1'b1;
  logic [7:0]    keycode = 8'h00;
  logic          upd_req;
  logic [IW-1:0] upd_idx;
  logic [7:0]    upd_key;
  logic [9:0]    upd_x, upd_y, upd_vx, upd_vy;
  logic          upd_ack = 1'b0;
  logic [9:0]    new_x = 10'd0, new_y = 10'd0, new_vx = 10'd0, new_vy = 10'd0;
  logic [IW-1:0] rd_idx = '0;
  logic [9:0]    rd_x, rd_y;
  logic          busy, frame_done, overrun, ack_timeout;

  ball_update_scheduler #(.NUM_BALLS(N), .IDX_W(IW), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Reset(Reset), .vs(vs), .keycode(keycode),
    .upd_req(upd_req), .upd_idx(upd_idx), .upd_key(upd_key),
    .upd_x(upd_x), .upd_y(upd_y), .upd_vx(upd_vx), .upd_vy(upd_vy),
    .upd_ack(upd_ack), .new_x(new_x), .new_y(new_y), .new_vx(new_vx), .new_vy(new_vy),
    .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y),
    .busy(busy), .frame_done(frame_done), .overrun(overrun), .ack_timeout(ack_timeout)
  );

  always #5 Clk = ~Clk;

  int         checks = 0;
  int         errors = 0;
  logic [9:0] mx[N], my[N], mvx[N], mvy[N];
  int         delay[N];
  int         vs_pulse;
  int         reset_at;
  bit         fixed_new;
  bit         exp_timeout;
  bit         exp_overrun;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i]  = 10'((80 + 120 * i) % 1024);
      my[i]  = 10'd240;
      mvx[i] = 10'd1;
      mvy[i] = 10'd1;
    end
    exp_timeout = 1'b0;
    exp_overrun = 1'b0;
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    upd_ack = 1'b0;
    vs = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    model_reset();
  endtask

  // One frame: falling vs, then serve every slot with delay[k] idle cycles before ack (>=TO means never).
  task automatic serve(input logic [7:0] key);
    int cyc = 0;
    keycode = key;
    vs = 1'b0;
    @(negedge Clk);
    vs = 1'b1;
    checks++;
    if (upd_req !== 1'b0) begin
      errors++; $display("FAIL early_req got %0b want 0", upd_req);
    end
    @(negedge Clk);
    keycode = 8'($urandom);
    for (int k = 0; k < N; k++) begin
      int w = 0;
      bit done = 0;
      while (!done) begin
        if (reset_at == k && w == 1) begin
          pulse_reset();
          return;
        end
        vs = (cyc == vs_pulse) ? 1'b0 : 1'b1;
        cyc++;
        checks++;
        if (upd_req !== 1'b1 || busy !== 1'b1 || upd_idx !== IW'(k) || upd_x !== mx[k] ||
            upd_y !== my[k] || upd_vx !== mvx[k] || upd_vy !== mvy[k]) begin
          errors++;
          $display("FAIL payload k=%0d w=%0d got req=%0b busy=%0b idx=%0d x=%0d y=%0d vx=%0d vy=%0d want idx=%0d x=%0d y=%0d vx=%0d vy=%0d",
                   k, w, upd_req, busy, upd_idx, upd_x, upd_y, upd_vx, upd_vy, k, mx[k], my[k], mvx[k], mvy[k]);
        end
        checks++;
        if (upd_key !== ((k == 0) ? key : 8'h00)) begin
          errors++; $display("FAIL upd_key k=%0d got %h want %h", k, upd_key, (k == 0) ? key : 8'h00);
        end
        checks++;
        if (ack_timeout !== exp_timeout) begin
          errors++; $display("FAIL ack_timeout k=%0d w=%0d got %0b want %0b", k, w, ack_timeout, exp_timeout);
        end
        if (w == delay[k]) begin
          logic [9:0] nx, ny, nvx, nvy;
          nx  = fixed_new ? 10'(k + 10) : 10'($urandom);
          ny  = 10'($urandom);
          nvx = 10'($urandom);
          nvy = 10'($urandom);
          upd_ack = 1'b1; new_x = nx; new_y = ny; new_vx = nvx; new_vy = nvy;
          @(posedge Clk);
          mx[k] = nx; my[k] = ny; mvx[k] = nvx; mvy[k] = nvy;
          done = 1;
        end else begin
          upd_ack = 1'b0;
          new_x = 10'($urandom); new_y = 10'($urandom);
          @(posedge Clk);
          if (w == TO - 1) begin
            exp_timeout = 1'b1;
            done = 1;
          end
        end
        w++;
        @(negedge Clk);
      end
    end
    upd_ack = 1'b0;
    vs = 1'b1;
    checks++;
    if (frame_done !== 1'b1 || busy !== 1'b0 || upd_req !== 1'b0) begin
      errors++; $display("FAIL pass_end got done=%0b busy=%0b req=%0b want 1 0 0", frame_done, busy, upd_req);
    end
    checks++;
    if (ack_timeout !== exp_timeout) begin
      errors++; $display("FAIL timeout_end got %0b want %0b", ack_timeout, exp_timeout);
    end
    @(negedge Clk);
    checks++;
    if (frame_done !== 1'b0) begin
      errors++; $display("FAIL done_pulse got %0b want 0", frame_done);
    end
    for (int i = 0; i < N; i++) begin
      rd_idx = IW'(i);
      #1;
      checks++;
      if (rd_x !== mx[i] || rd_y !== my[i]) begin
        errors++; $display("FAIL slot%0d got (%0d,%0d) want (%0d,%0d)", i, rd_x, rd_y, mx[i], my[i]);
      end
    end
  endtask

  task automatic set_delays(input int d0, input int d1, input int d2, input int d3);
    delay[0] = d0; delay[1] = d1; delay[2] = d2; delay[3] = d3;
    vs_pulse = -1; reset_at = -1; fixed_new = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    checks++;
    if (upd_req !== 0 || busy !== 0 || frame_done !== 0 || overrun !== 0 || ack_timeout !== 0 ||
        upd_idx !== 0 || upd_key !== 0 || upd_x !== 0 || upd_y !== 0 || upd_vx !== 0 || upd_vy !== 0) begin
      errors++;
      $display("FAIL reset_outputs got req=%0b busy=%0b done=%0b ovr=%0b to=%0b idx=%0d key=%h x=%0d want all 0",
               upd_req, busy, frame_done, overrun, ack_timeout, upd_idx, upd_key, upd_x);
    end
    for (int i = 0; i < 6; i++) begin
      logic [9:0] ex, ey;
      ex = (i < N) ? mx[i] : 10'd0;
      ey = (i < N) ? my[i] : 10'd0;
      rd_idx = IW'(i);
      #1;
      checks++;
      if (rd_x !== ex || rd_y !== ey) begin
        errors++; $display("FAIL reset_rd%0d got (%0d,%0d) want (%0d,%0d)", i, rd_x, rd_y, ex, ey);
      end
    end
    @(negedge Clk);
  endtask

  task automatic test_back_to_back();
    set_delays(0, 0, 0, 0);
    fixed_new = 1;
    serve(8'h1A);
    rd_idx = 2;
    #1;
    checks++;
    if (rd_x !== 10'd12) begin
      errors++; $display("FAIL rd_x2 got %0d want 12", rd_x);
    end
    for (int r = 0; r < 3; r++) begin
      set_delays(0, 0, 0, 0);
      serve(8'($urandom));
    end
  endtask

  task automatic test_slow_ack();
    set_delays(0, 4, 0, 0);
    serve(8'($urandom));
    for (int r = 0; r < 3; r++) begin
      set_delays($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6));
      serve(8'($urandom));
    end
  endtask

  task automatic test_timeout();
    set_delays(1, 0, 1000, 2);
    serve(8'h33);
  endtask

  task automatic test_overrun();
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL overrun_pre got %0b want 0", overrun);
    end
    set_delays(0, 4, 0, 0);
    vs_pulse = 0;
    serve(8'h44);
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_set got %0b want 1", overrun);
    end
    set_delays(0, 0, 0, 0);
    serve(8'h55);
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_sticky got %0b want 1", overrun);
    end
  endtask

  task automatic test_overrun_at_completion();
    pulse_reset();
    set_delays(0, 0, 0, 0);
    vs_pulse = 2;
    serve(8'h66);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (upd_req !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL no_second_pass c=%0d got req=%0b busy=%0b want 0 0", c, upd_req, busy);
      end
      @(negedge Clk);
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_same_cycle got %0b want 1", overrun);
    end
  endtask

  task automatic test_idle_ack();
    for (int c = 0; c < 5; c++) begin
      upd_ack = 1'b1;
      new_x = 10'($urandom); new_y = 10'($urandom); new_vx = 10'($urandom); new_vy = 10'($urandom);
      @(negedge Clk);
      checks++;
      if (upd_req !== 1'b0) begin
        errors++; $display("FAIL idle_req c=%0d got %0b want 0", c, upd_req);
      end
    end
    upd_ack = 1'b0;
    for (int i = 0; i < N; i++) begin
      rd_idx = IW'(i);
      #1;
      checks++;
      if (rd_x !== mx[i] || rd_y !== my[i]) begin
        errors++; $display("FAIL idle_ack_slot%0d got (%0d,%0d) want (%0d,%0d)", i, rd_x, rd_y, mx[i], my[i]);
      end
    end
    @(negedge Clk);
  endtask

  task automatic test_reset_mid_pass();
    set_delays(0, 1000, 0, 0);
    serve(8'h77);
    set_delays(0, 0, 3, 0);
    reset_at = 2;
    serve(8'h88);
    checks++;
    if (upd_req !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || ack_timeout !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got req=%0b busy=%0b ovr=%0b to=%0b want 0 0 0 0", upd_req, busy, overrun, ack_timeout);
    end
    for (int i = 0; i < N; i++) begin
      rd_idx = IW'(i);
      #1;
      checks++;
      if (rd_x !== mx[i] || rd_y !== my[i]) begin
        errors++; $display("FAIL mid_reset_slot%0d got (%0d,%0d) want (%0d,%0d)", i, rd_x, rd_y, mx[i], my[i]);
      end
    end
    @(negedge Clk);
    set_delays(0, 0, 0, 0);
    serve(8'h99);
  endtask

  initial begin
    model_reset();
    set_delays(0, 0, 0, 0);
    test_reset();
    test_back_to_back();
    test_slow_ack();
    test_timeout();
    test_overrun();
    test_idle_ack();
    test_overrun_at_completion();
    test_reset_mid_pass();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ball_update_scheduler.md
Name: ball_update_scheduler

Overview:
- Sequences the once-per-frame motion update for NUM_BALLS ball objects.
- One shared motion-update unit is time-multiplexed across all slots via a req/ack handshake; this block holds position/velocity state for every slot.
- Frame start is the falling edge of VGA vs; the color mapper reads positions through a combinational read port.
- Sits between vga_controller (vs), the shared motion unit and color_mapper.

Parameters:
- NUM_BALLS, 4, number of ball slots (2..16).
- IDX_W, 4, slot index width (2^IDX_W >= NUM_BALLS).
- X_INIT, 10'd80, reset X of slot 0.
- X_SPACING, 10'd120, reset X increment per slot.
- Y_INIT, 10'd240, reset Y of all slots.
- TIMEOUT, 64, max cycles to wait for upd_ack per slot.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- vs  in  1  VGA vertical sync, active low, synchronous to Clk.
- keycode  in  8  keyboard code, sampled at frame start.
- upd_req  out  1  request to shared motion unit.
- upd_idx  out  IDX_W  slot being updated.
- upd_key  out  8  sampled keycode for slot 0, 8'h00 for all other slots.
- upd_x, upd_y, upd_vx, upd_vy  out  10 each  current slot state (vx/vy two's complement).
- upd_ack  in  1  motion unit result valid.
- new_x, new_y, new_vx, new_vy  in  10 each  updated slot state, valid when upd_ack=1.
- rd_idx  in  IDX_W  color mapper read index.
- rd_x, rd_y  out  10 each  combinational read of slot rd_idx; 10'd0 if rd_idx >= NUM_BALLS.
- busy  out  1  update pass in progress.
- frame_done  out  1  one-cycle pulse when the pass completes.
- overrun  out  1  sticky: frame start arrived while busy.
- ack_timeout  out  1  sticky: some slot timed out.

Behaviour:
- Reset:
  - slot i x = X_INIT + i*X_SPACING (truncated to 10 bits), y = Y_INIT, vx = 10'd1, vy = 10'd1.
  - All outputs 0; state IDLE; idx 0; timeout counter 0; vs_prev register = 1.
- Frame start (fs) = vs_prev & ~vs, registered once.
- States:
  - IDLE: busy=0, upd_req=0. On fs: latch keycode into key_reg, idx<=0, cnt<=0, go REQ. upd_req rises the cycle after fs is detected.
  - REQ: busy=1, upd_req=1. upd_idx=idx; upd_x/y/vx/vy reflect slot idx; upd_key = (idx==0) ? key_reg : 0.
    - Payload is stable while upd_req=1 and upd_ack=0.
    - upd_ack=1: write new_* into slot idx at that edge; cnt<=0. If idx==NUM_BALLS-1, go IDLE and pulse frame_done the next cycle. Otherwise idx<=idx+1 and stay in REQ; upd_req stays high, so back-to-back slots take 1 cycle each if ack is held.
    - No ack and cnt==TIMEOUT-1: slot keeps its old state; set ack_timeout; advance exactly as on an ack (including frame_done on the last slot).
    - Otherwise cnt<=cnt+1.
- Ignore upd_ack in IDLE; it must not write any slot.
- fs while busy: set overrun, ignore the fs; the current pass continues unchanged.
- fs and pass completion in the same cycle: still counts as overrun; no new pass starts.
- Reset mid-pass: all slots reinitialised; upd_req drops the next cycle; sticky flags cleared. Only Reset clears the sticky flags.
- Read port: a write to slot k on edge t is visible on rd_x/rd_y from edge t onward (no extra latency).
- Best-case pass latency: NUM_BALLS+1 cycles from fs detection to frame_done, with ack tied high.

Test Plan:
- Reset, then read rd_idx 0..3 -> (80,240), (200,240), (320,240), (440,240); rd_idx 5 -> (0,0); all outputs 0.
- vs 1->0 with keycode=8'h1A and upd_ack tied 1, new_x=idx+10 -> upd_req high for 4 cycles; upd_idx 0,1,2,3; upd_key 8'h1A only at idx 0; frame_done pulses one cycle later; rd_x[2]=12.
- Motion unit acks slot 1 after 5 cycles -> payload for idx 1 holds stable 5 cycles; busy=1 throughout; slot 1 is written exactly once.
- Never ack slot 2, TIMEOUT=64 -> after 64 cycles ack_timeout=1; slot 2 unchanged; idx advances to 3; pass completes with frame_done.
- Second vs falling edge while busy -> overrun=1; pass finishes normally; no second pass starts; next vs falling edge in IDLE starts a pass.
- Reset asserted while idx=2 -> next cycle upd_req=0, busy=0, slots back to reset values, overrun=0, ack_timeout=0.
